// File: rtl/io_chan_ctrl.sv
// io_chan_ctrl: multi-channel I/O controller for the basic-computer CPU.
//
// Each of NCH channels has:
//   - a DEPTH-entry input FIFO that the device fills and INP pops,
//   - a one-entry output buffer that OUT loads and the device drains,
//   - per-direction interrupt mask bits,
//   - sticky error flags for INP-on-empty and OUT-on-full.
// A prioritised, vectored interrupt request is registered every run cycle.
//
// Ports
//   clk, rst_n                system clock, async active-low reset
//   run                       1 = advance, 0 = freeze all state
//   sel, inp, outp, wdata     CPU IO instruction: channel select, INP/OUT strobes, OUT data
//   rdata, fgi, fgo           head of selected FIFO, FIFO non-empty, out buffer empty
//   imsk_we, imsk_wdata, imsk interrupt mask write and readback
//   ien, irq, irq_vec         interrupt enable, registered request and {channel, dir}
//   err_clr, err_rd, err_wr   sticky error clear and flags
//   in_valid/in_data/in_ready    device -> controller byte handshake
//   out_valid/out_data/out_ready controller -> device byte handshake
module io_chan_ctrl #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [CW-1:0]        sel,
  input  logic                 inp,
  input  logic                 outp,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  output logic                 fgi,
  output logic                 fgo,
  input  logic                 imsk_we,
  input  logic [2*NCH-1:0]     imsk_wdata,
  output logic [2*NCH-1:0]     imsk,
  input  logic                 ien,
  output logic                 irq,
  output logic [CW:0]          irq_vec,
  input  logic                 err_clr,
  output logic [NCH-1:0]       err_rd,
  output logic [NCH-1:0]       err_wr,
  input  logic [NCH-1:0]       in_valid,
  input  logic [8*NCH-1:0]     in_data,
  output logic [NCH-1:0]       in_ready,
  output logic [NCH-1:0]       out_valid,
  output logic [8*NCH-1:0]     out_data,
  input  logic [NCH-1:0]       out_ready
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      mem_q       [NCH][DEPTH];
  logic [PtrW-1:0] rptr_q      [NCH];
  logic [PtrW-1:0] wptr_q      [NCH];
  logic [CntW-1:0] cnt_q       [NCH];
  logic [7:0]      obuf_data_q [NCH];
  logic [NCH-1:0]  obuf_full_q;
  logic [NCH-1:0]  err_rd_q, err_wr_q;
  logic [2*NCH-1:0] imsk_q;
  logic            irq_q;
  logic [CW:0]     irq_vec_q;

  logic [NCH-1:0] hit, empty, full, push, pop, load, done, set_rd, set_wr;
  logic           pend_any;
  logic [CW:0]    pend_vec;

  // Per-channel control decode and device-side handshakes.
  always_comb begin
    hit       = '0;
    empty     = '0;
    full      = '0;
    push      = '0;
    pop       = '0;
    load      = '0;
    done      = '0;
    set_rd    = '0;
    set_wr    = '0;
    in_ready  = '0;
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      // Out-of-range sel matches no channel.
      hit[i]       = (int'(sel) == i);
      empty[i]     = (cnt_q[i] == '0);
      full[i]      = (cnt_q[i] == CntW'(DEPTH));
      in_ready[i]  = run & ~full[i];
      push[i]      = in_valid[i] & in_ready[i];
      pop[i]       = run & inp & hit[i] & ~empty[i];
      set_rd[i]    = run & inp & hit[i] & empty[i];
      out_valid[i] = run & obuf_full_q[i];
      done[i]      = out_valid[i] & out_ready[i];
      load[i]      = run & outp & hit[i];
      set_wr[i]    = load[i] & obuf_full_q[i] & ~done[i];
      out_data[8*i +: 8] = obuf_data_q[i];
    end
  end

  // CPU-side combinational view of the selected channel.
  always_comb begin
    rdata = '0;
    fgi   = 1'b0;
    fgo   = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (hit[i]) begin
        if (!empty[i]) rdata = mem_q[i][rptr_q[i]];
        fgi = ~empty[i];
        fgo = ~obuf_full_q[i];
      end
    end
  end

  // Priority encode: scan high to low so the lowest channel wins, and test
  // input after output so input wins within a channel.
  always_comb begin
    pend_any = 1'b0;
    pend_vec = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (!obuf_full_q[i] && imsk_q[2*i]) begin
        pend_any = 1'b1;
        pend_vec = {CW'(i), 1'b0};
      end
      if (!empty[i] && imsk_q[2*i+1]) begin
        pend_any = 1'b1;
        pend_vec = {CW'(i), 1'b1};
      end
    end
  end

  // FIFO storage needs no reset: reads of an empty FIFO are masked to 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NCH); i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCH); i++) begin
        rptr_q[i]      <= '0;
        wptr_q[i]      <= '0;
        cnt_q[i]       <= '0;
        obuf_data_q[i] <= '0;
      end
      obuf_full_q <= '0;
      err_rd_q    <= '0;
      err_wr_q    <= '0;
      imsk_q      <= '0;
      irq_q       <= 1'b0;
      irq_vec_q   <= '0;
    end else if (run) begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PtrW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PtrW'(1);
        if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + CntW'(1);
        else if (pop[i] && !push[i]) cnt_q[i] <= cnt_q[i] - CntW'(1);
        // A load in the same cycle as a completing transfer refills the buffer.
        if (load[i] && (!obuf_full_q[i] || done[i])) begin
          obuf_data_q[i] <= wdata;
          obuf_full_q[i] <= 1'b1;
        end else if (done[i]) begin
          obuf_full_q[i] <= 1'b0;
        end
      end
      // Set wins over clear.
      err_rd_q  <= (err_clr ? '0 : err_rd_q) | set_rd;
      err_wr_q  <= (err_clr ? '0 : err_wr_q) | set_wr;
      if (imsk_we) imsk_q <= imsk_wdata;
      irq_q     <= ien & pend_any;
      irq_vec_q <= pend_vec;
    end
  end

  assign imsk    = imsk_q;
  assign err_rd  = err_rd_q;
  assign err_wr  = err_wr_q;
  assign irq     = irq_q;
  assign irq_vec = irq_vec_q;

endmodule

// File: tb/tb_io_chan_ctrl.sv
module tb_io_chan_ctrl;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             rst_n, run, inp, outp, imsk_we, ien, err_clr;
  logic [CW-1:0]    sel;
  logic [7:0]       wdata, rdata;
  logic             fgi, fgo, irq;
  logic [2*NCH-1:0] imsk_wdata, imsk;
  logic [CW:0]      irq_vec;
  logic [NCH-1:0]   err_rd, err_wr, in_valid, in_ready, out_valid, out_ready;
  logic [8*NCH-1:0] in_data, out_data;

  always #5 clk = ~clk;

  io_chan_ctrl #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .sel(sel), .inp(inp), .outp(outp),
    .wdata(wdata), .rdata(rdata), .fgi(fgi), .fgo(fgo), .imsk_we(imsk_we),
    .imsk_wdata(imsk_wdata), .imsk(imsk), .ien(ien), .irq(irq), .irq_vec(irq_vec),
    .err_clr(err_clr), .err_rd(err_rd), .err_wr(err_wr), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue per input FIFO, a flag+byte per output buffer.
  logic [7:0]       mq [NCH][$];
  logic [NCH-1:0]   m_full, m_err_rd, m_err_wr;
  logic [7:0]       m_obuf [NCH];
  logic [2*NCH-1:0] m_imsk;
  logic             m_irq;
  int               m_vec;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      m_obuf[i] = 8'h00;
    end
    m_full = '0; m_err_rd = '0; m_err_wr = '0; m_imsk = '0; m_irq = 1'b0; m_vec = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_step();
    logic [NCH-1:0] set_rd, set_wr;
    bit any;
    int vec;
    if (!run) return;
    any = 0; vec = 0;
    for (int i = 0; i < NCH; i++) begin
      if (!any && mq[i].size() > 0 && m_imsk[2*i+1]) begin any = 1; vec = 2*i + 1; end
      if (!any && !m_full[i] && m_imsk[2*i]) begin any = 1; vec = 2*i; end
    end
    set_rd = '0; set_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      bit push, hit, done;
      push = in_valid[i] && (mq[i].size() < DEPTH);
      hit  = (int'(sel) == i);
      done = m_full[i] && out_ready[i];
      if (inp && hit) begin
        if (mq[i].size() > 0) void'(mq[i].pop_front());
        else set_rd[i] = 1'b1;
      end
      if (push) mq[i].push_back(in_data[8*i +: 8]);
      if (outp && hit) begin
        if (!m_full[i] || done) begin m_obuf[i] = wdata; m_full[i] = 1'b1; end
        else set_wr[i] = 1'b1;
      end else if (done) begin
        m_full[i] = 1'b0;
      end
    end
    if (err_clr) begin m_err_rd = '0; m_err_wr = '0; end
    m_err_rd |= set_rd;
    m_err_wr |= set_wr;
    if (imsk_we) m_imsk = imsk_wdata;
    m_irq = ien && any;
    m_vec = any ? vec : 0;
  endfunction

  // Compare process: check every cycle mid-period, then advance the model.
  always @(negedge clk) begin
    logic [7:0]     e_rdata;
    logic           e_fgi, e_fgo;
    logic [NCH-1:0] e_ir, e_ov;
    if (!rst_n) model_reset();
    e_rdata = 8'h00; e_fgi = 1'b0; e_fgo = 1'b0;
    if (int'(sel) < NCH) begin
      if (mq[sel].size() > 0) begin e_rdata = mq[sel][0]; e_fgi = 1'b1; end
      e_fgo = !m_full[sel];
    end
    for (int i = 0; i < NCH; i++) begin
      e_ir[i] = run && (mq[i].size() < DEPTH);
      e_ov[i] = run && m_full[i];
    end
    check("rdata", rdata, e_rdata);
    check("fgi", fgi, e_fgi);
    check("fgo", fgo, e_fgo);
    check("in_ready", in_ready, e_ir);
    check("out_valid", out_valid, e_ov);
    check("imsk", imsk, m_imsk);
    check("err_rd", err_rd, m_err_rd);
    check("err_wr", err_wr, m_err_wr);
    check("irq", irq, m_irq);
    check("irq_vec", irq_vec, m_vec[CW:0]);
    for (int i = 0; i < NCH; i++)
      if (m_full[i]) check("out_data", out_data[8*i +: 8], m_obuf[i]);
    if (rst_n) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    inp = 0; outp = 0; imsk_we = 0; err_clr = 0; in_valid = '0;
  endtask

  logic [7:0] pat [4];

  initial begin
    rst_n = 0; run = 0; sel = '0; inp = 0; outp = 0; wdata = '0; imsk_we = 0;
    imsk_wdata = '0; ien = 0; err_clr = 0; in_valid = '0; in_data = '0; out_ready = '0;
    repeat (2) tick();
    rst_n = 1; run = 1;

    // Reset state on every channel.
    for (int s = 0; s < NCH; s++) begin
      sel = CW'(s);
      settle();
      check("rst_fgo", fgo, 1'b1);
      check("rst_fgi", fgi, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_in_ready", in_ready, 4'hF);
      check("rst_out_valid", out_valid, 4'h0);
      check("rst_irq", irq, 1'b0);
      tick();
    end

    // FIFO fill, pop, simultaneous push/pop on ch2.
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0100; in_data[23:16] = pat[k];
      tick();
    end
    clr();
    inp = 1;
    settle();
    check("full_in_ready2", in_ready[2], 1'b0);
    check("pop1", rdata, 8'h11);
    tick();
    in_valid = 4'b0100; in_data[23:16] = 8'h55;
    settle();
    check("pop2", rdata, 8'h22);
    tick();
    in_valid = '0;
    settle();
    check("cnt3_in_ready2", in_ready[2], 1'b1);
    check("pop3", rdata, 8'h33);
    tick();
    settle();
    check("pop4", rdata, 8'h44);
    tick();
    settle();
    check("pop5", rdata, 8'h55);
    tick();
    clr();
    settle();
    check("drained_fgi", fgi, 1'b0);
    tick();

    // Read errors on empty ch1.
    sel = 2'd1; inp = 1;
    settle();
    check("empty_rdata", rdata, 8'h00);
    tick();
    clr();
    settle();
    check("err_rd_set", err_rd[1], 1'b1);
    tick();
    err_clr = 1;
    tick();
    clr();
    settle();
    check("err_rd_clr", err_rd[1], 1'b0);
    tick();
    err_clr = 1; inp = 1;
    tick();
    clr();
    settle();
    check("err_rd_set_wins", err_rd[1], 1'b1);
    tick();

    // Output buffer on ch0.
    sel = 2'd0; outp = 1; wdata = 8'hA5; out_ready = '0; err_clr = 1;
    tick();
    clr();
    settle();
    check("ov0_loaded", out_valid[0], 1'b1);
    tick();
    outp = 1; wdata = 8'h5A;
    tick();
    clr();
    settle();
    check("err_wr_set", err_wr[0], 1'b1);
    check("out_kept", out_data[7:0], 8'hA5);
    tick();
    err_clr = 1;
    tick();
    clr(); outp = 1; wdata = 8'h77; out_ready = 4'b0001;
    tick();
    clr(); out_ready = '0;
    settle();
    check("ov0_reload", out_valid[0], 1'b1);
    check("out_reload", out_data[7:0], 8'h77);
    check("no_err_wr", err_wr[0], 1'b0);
    tick();
    out_ready = 4'b0001;
    tick();
    out_ready = '0;

    // Interrupt priority.
    imsk_we = 1; imsk_wdata = 8'h0A; ien = 1; in_valid = 4'b0010; in_data[15:8] = 8'h99;
    tick();
    clr();
    tick();
    in_valid = 4'b0001; in_data[7:0] = 8'h42;
    settle();
    check("irq_ch1", irq, 1'b1);
    check("vec_ch1_in", irq_vec, 3'b011);
    tick();
    clr();
    tick();
    ien = 0;
    settle();
    check("vec_ch0_in", irq_vec, 3'b001);
    tick();
    settle();
    check("irq_off", irq, 1'b0);
    tick();

    // Freeze with run=0, then asynchronous reset mid-stream.
    sel = 2'd3; in_valid = 4'b1000; in_data[31:24] = 8'hC3; outp = 1; wdata = 8'h3C;
    tick();
    clr(); run = 0; in_valid = 4'hF; out_ready = 4'hF;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("frz_in_ready", in_ready, 4'h0);
      check("frz_out_valid", out_valid, 4'h0);
      check("frz_fgi", fgi, 1'b1);
      tick();
    end
    run = 1; clr(); out_ready = '0;
    tick();
    rst_n = 0;
    settle();
    check("arst_fgi", fgi, 1'b0);
    check("arst_imsk", imsk, 8'h00);
    tick();
    rst_n = 1;
    tick();

    // Randomised traffic checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      run        = ($urandom_range(9) != 0);
      rst_n      = ($urandom_range(499) != 0);
      sel        = CW'($urandom);
      inp        = ($urandom_range(3) == 0);
      outp       = ($urandom_range(3) == 0);
      wdata      = 8'($urandom);
      imsk_we    = ($urandom_range(15) == 0);
      imsk_wdata = 8'($urandom);
      ien        = ($urandom_range(7) != 0);
      err_clr    = ($urandom_range(15) == 0);
      in_valid   = 4'($urandom) & 4'($urandom);
      in_data    = $urandom;
      out_ready  = 4'($urandom) & 4'($urandom);
      tick();
    end
    rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
